// File: rtl/xiphos_mem_pkg.sv
// ============================================================================
// Module      : xiphos_mem_pkg
// Description : Shared constants and loader FSM state encoding for the
//               4K x 16 data RAM subsystem.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package xiphos_mem_pkg;

    localparam int ADDR_W    = 12;
    localparam int DATA_W    = 16;
    localparam int RAM_DEPTH = 4096;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HI    = 3'd1,
        LO    = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } loader_state_t;

endpackage

`default_nettype wire

// File: rtl/ram_loader.sv
// ============================================================================
// Module      : ram_loader
// Description : Packs a valid/ready byte stream into 16-bit words (high byte
//               first) and writes them to consecutive RAM addresses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_loader #(
    parameter int ADDR_W = xiphos_mem_pkg::ADDR_W,
    parameter int DATA_W = xiphos_mem_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   count,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic [DATA_W-1:0] ram_in,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_ld,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   words_written
);
    import xiphos_mem_pkg::*;

    localparam logic [ADDR_W:0] c_one = {{ADDR_W{1'b0}}, 1'b1};

    loader_state_t     state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W:0]   ww_q, ww_d;
    logic [7:0]        hi_q, hi_d;
    logic [DATA_W-1:0] ram_in_q, ram_in_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;

    // The write index and the words_written count always move together,
    // so a single counter serves both roles.
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        count_d    = count_q;
        ww_d       = ww_q;
        hi_d       = hi_q;
        ram_in_d   = ram_in_q;
        ram_addr_d = ram_addr_q;
        byte_ready = 1'b0;
        ram_ld     = 1'b0;
        done       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    base_d  = base_addr;
                    count_d = count;
                    ww_d    = '0;
                    state_d = (count == '0) ? DONE : HI;
                end
            end
            HI: begin
                byte_ready = 1'b1;
                if (abort) begin
                    state_d = IDLE;
                end else if (byte_valid) begin
                    hi_d    = byte_in;
                    state_d = LO;
                end
            end
            LO: begin
                byte_ready = 1'b1;
                if (abort) begin
                    state_d = IDLE;
                end else if (byte_valid) begin
                    ram_in_d   = {hi_q, byte_in};
                    ram_addr_d = base_q + ww_q[ADDR_W-1:0];
                    state_d    = WRITE;
                end
            end
            WRITE: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    ram_ld  = 1'b1;
                    ww_d    = ww_q + c_one;
                    state_d = (ww_q + c_one == count_q) ? DONE : HI;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            base_q     <= '0;
            count_q    <= '0;
            ww_q       <= '0;
            hi_q       <= '0;
            ram_in_q   <= '0;
            ram_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            count_q    <= count_d;
            ww_q       <= ww_d;
            hi_q       <= hi_d;
            ram_in_q   <= ram_in_d;
            ram_addr_q <= ram_addr_d;
        end
    end

    assign busy          = (state_q != IDLE);
    assign ram_in        = ram_in_q;
    assign ram_addr      = ram_addr_q;
    assign words_written = ww_q;

endmodule

`default_nettype wire
